// File: rtl/hazard_pkg.sv
// hazard_pkg
// Shared types and helpers for the hazard/forwarding slice.
//   tag_entry_t    : one in-flight destination tag {we, rd, is_load}
//   BUBBLE         : tag entry that never matches any source operand
//   fwd_sel_width  : width of one per-port forwarding select
// The rd field is TAG_RA_MAX bits wide, so NREG up to 2**TAG_RA_MAX is
// supported. Narrower register addresses are zero-extended into it.
package hazard_pkg;

  localparam int TAG_RA_MAX = 8;

  typedef struct packed {
    logic                  we;
    logic [TAG_RA_MAX-1:0] rd;
    logic                  is_load;
  } tag_entry_t;

  localparam tag_entry_t BUBBLE = '{we: 1'b0, rd: '0, is_load: 1'b0};

  // Select encodes 0 = register file, k+1 = stage k.
  function automatic int fwd_sel_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/hazard_tag_pipe.sv
// hazard_tag_pipe
// FWD_DEPTH-entry shift register of in-flight destination tags.
// Every rising edge each stage moves one position older. The oldest entry
// drops off because its register-file write lands on that same edge.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset (clears all tags)
//   entry_in       : decode tag offered to stage 0
//   insert_bubble  : load stage 0 with BUBBLE instead of entry_in
//   stage_q        : current tag of every stage (index 0 = youngest)
module hazard_tag_pipe
  import hazard_pkg::*;
#(
  parameter int FWD_DEPTH = 3
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  tag_entry_t                   entry_in,
  input  logic                         insert_bubble,
  output tag_entry_t [FWD_DEPTH-1:0]   stage_q
);

  tag_entry_t [FWD_DEPTH-1:0] stage_reg;

  genvar gi;
  generate
    for (gi = 0; gi < FWD_DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            stage_reg[gi] <= BUBBLE;
          end else begin
            stage_reg[gi] <= insert_bubble ? BUBBLE : entry_in;
          end
        end
      end else begin : g_body
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            stage_reg[gi] <= BUBBLE;
          end else begin
            stage_reg[gi] <= stage_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  assign stage_q = stage_reg;

endmodule

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit
// Hazard detection and operand forwarding between decode and execute.
// It tracks one destination tag per post-decode stage. For every source
// port it picks the youngest matching stage as bypass data. It stalls decode
// on a load-use hazard and squashes decode slots after a taken redirect.
// Ports:
//   clk, reset_n            : clock, asynchronous active-low reset
//   id_valid_i              : decode holds a valid instruction
//   id_rs_en_i/id_rs_addr_i : per-port source enable / register address
//   id_rd_we_i/id_rd_addr_i : decode destination write enable / register
//   id_is_load_i            : decode instruction is a load
//   rf_data_i               : register-file read data per port
//   stage_data_i            : result currently held in each stage
//   redirect_i              : taken jump/branch resolved in EX this cycle
//   fwd_data_o/fwd_sel_o    : resolved operand / source select per port
//   stall_o                 : hold PC and IF/ID, bubble into stage 0
//   kill_o                  : squash the decode slot
//   stage_we_o/stage_rd_o   : registered tag of every stage
// Optional feature macro HAZARD_STATS_EN adds stall_count_o and
// kill_count_o. These are saturating 32-bit counts of stall and kill cycles.
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int XLEN             = 32,
  parameter int NREG             = 32,
  parameter int NRD              = 2,
  parameter int FWD_DEPTH        = 3,
  parameter int LOAD_STAGE       = 1,
  parameter int REDIRECT_BUBBLES = 2
) (
  input  logic                                      clk,
  input  logic                                      reset_n,
  input  logic                                      id_valid_i,
  input  logic [NRD-1:0]                            id_rs_en_i,
  input  logic [NRD*$clog2(NREG)-1:0]               id_rs_addr_i,
  input  logic                                      id_rd_we_i,
  input  logic [$clog2(NREG)-1:0]                   id_rd_addr_i,
  input  logic                                      id_is_load_i,
  input  logic [NRD*XLEN-1:0]                       rf_data_i,
  input  logic [FWD_DEPTH*XLEN-1:0]                 stage_data_i,
  input  logic                                      redirect_i,
  output logic [NRD*XLEN-1:0]                       fwd_data_o,
  output logic [NRD*fwd_sel_width(FWD_DEPTH)-1:0]   fwd_sel_o,
  output logic                                      stall_o,
  output logic                                      kill_o,
  output logic [FWD_DEPTH-1:0]                      stage_we_o,
  output logic [FWD_DEPTH*$clog2(NREG)-1:0]         stage_rd_o
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]                               stall_count_o,
  output logic [31:0]                               kill_count_o
`endif
);

  localparam int RA = $clog2(NREG);
  localparam int SW = fwd_sel_width(FWD_DEPTH);
  localparam int CW = $clog2(REDIRECT_BUBBLES + 1);

  tag_entry_t [FWD_DEPTH-1:0] stage_q;
  tag_entry_t                 dec_entry;
  logic                       insert_bubble;
  logic [NRD-1:0]             port_load_use;
  logic [CW-1:0]              redir_cnt_reg;
  logic [CW-1:0]              redir_cnt_next;

  assign dec_entry = '{we: id_rd_we_i, rd: TAG_RA_MAX'(id_rd_addr_i),
                       is_load: id_is_load_i};

  // A stalled or squashed decode slot must not enter the pipeline.
  assign insert_bubble = !(id_valid_i && !stall_o && !kill_o);

  hazard_tag_pipe #(
    .FWD_DEPTH (FWD_DEPTH)
  ) u_tag_pipe (
    .clk           (clk),
    .reset_n       (reset_n),
    .entry_in      (dec_entry),
    .insert_bubble (insert_bubble),
    .stage_q       (stage_q)
  );

  genvar gi;
  generate
    for (gi = 0; gi < FWD_DEPTH; gi++) begin : g_tag_out
      assign stage_we_o[gi]          = stage_q[gi].we;
      assign stage_rd_o[gi*RA +: RA] = stage_q[gi].rd[RA-1:0];
    end

    for (gi = 0; gi < NRD; gi++) begin : g_port
      logic [RA-1:0]   addr;
      logic [SW-1:0]   sel;
      logic [XLEN-1:0] data;
      logic            load_use;

      assign addr = id_rs_addr_i[gi*RA +: RA];

      // Scan from oldest to youngest so the youngest match overwrites.
      // The load-use flag follows the winning stage only. An older stage
      // with ready data is deliberately not used in its place.
      always_comb begin
        sel      = '0;
        data     = rf_data_i[gi*XLEN +: XLEN];
        load_use = 1'b0;
        for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
          if (id_rs_en_i[gi] && (addr != '0) && stage_q[k].we &&
              (stage_q[k].rd == TAG_RA_MAX'(addr))) begin
            sel      = SW'(k + 1);
            data     = stage_data_i[k*XLEN +: XLEN];
            load_use = stage_q[k].is_load && (k < LOAD_STAGE);
          end
        end
      end

      assign fwd_sel_o[gi*SW +: SW]    = sel;
      assign fwd_data_o[gi*XLEN +: XLEN] = data;
      assign port_load_use[gi]         = load_use;
    end
  endgenerate

  // The first squashed slot is the redirect cycle itself, so it is
  // combinational. The counter covers the remaining slots.
  assign kill_o  = redirect_i || (redir_cnt_reg != '0);
  assign stall_o = (|port_load_use) && !kill_o;

  always_comb begin
    redir_cnt_next = redir_cnt_reg;
    if (redirect_i) begin
      redir_cnt_next = CW'(REDIRECT_BUBBLES - 1);
    end else if (redir_cnt_reg != '0) begin
      redir_cnt_next = redir_cnt_reg - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      redir_cnt_reg <= '0;
    end else begin
      redir_cnt_reg <= redir_cnt_next;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_reg;
  logic [31:0] kill_cnt_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_reg <= '0;
      kill_cnt_reg  <= '0;
    end else begin
      if (stall_o && (stall_cnt_reg != '1)) begin
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
      end
      if (kill_o && (kill_cnt_reg != '1)) begin
        kill_cnt_reg <= kill_cnt_reg + 32'd1;
      end
    end
  end

  assign stall_count_o = stall_cnt_reg;
  assign kill_count_o  = kill_cnt_reg;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
module tb_hazard_forward_unit;

  localparam int XLEN = 32;
  localparam int NRD  = 2;
  localparam int FD   = 3;
  localparam int RA   = 5;
  localparam int SW   = 2;
  localparam logic [31:0] RF0 = 32'hAAAA_0000;
  localparam logic [31:0] RF1 = 32'hBBBB_0001;

  logic                 clk;
  logic                 reset_n;
  logic                 id_valid;
  logic [NRD-1:0]       id_rs_en;
  logic [NRD*RA-1:0]    id_rs_addr;
  logic                 id_rd_we;
  logic [RA-1:0]        id_rd_addr;
  logic                 id_is_load;
  logic [NRD*XLEN-1:0]  rf_data;
  logic [FD*XLEN-1:0]   stage_data;
  logic                 redirect;
  logic [NRD*XLEN-1:0]  fwd_data_o;
  logic [NRD*SW-1:0]    fwd_sel_o;
  logic                 stall_o;
  logic                 kill_o;
  logic [FD-1:0]        stage_we_o;
  logic [FD*RA-1:0]     stage_rd_o;
`ifdef HAZARD_STATS_EN
  logic [31:0]          stall_count_o;
  logic [31:0]          kill_count_o;
`endif

  hazard_forward_unit #(
    .XLEN(32), .NREG(32), .NRD(2), .FWD_DEPTH(3), .LOAD_STAGE(1),
    .REDIRECT_BUBBLES(2)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .id_valid_i   (id_valid),
    .id_rs_en_i   (id_rs_en),
    .id_rs_addr_i (id_rs_addr),
    .id_rd_we_i   (id_rd_we),
    .id_rd_addr_i (id_rd_addr),
    .id_is_load_i (id_is_load),
    .rf_data_i    (rf_data),
    .stage_data_i (stage_data),
    .redirect_i   (redirect),
    .fwd_data_o   (fwd_data_o),
    .fwd_sel_o    (fwd_sel_o),
    .stall_o      (stall_o),
    .kill_o       (kill_o),
    .stage_we_o   (stage_we_o),
    .stage_rd_o   (stage_rd_o)
`ifdef HAZARD_STATS_EN
    ,
    .stall_count_o(stall_count_o),
    .kill_count_o (kill_count_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observation layout equals {fwd_sel_o, fwd_data_o, stall_o, kill_o}.
  typedef struct packed {
    logic [1:0]  sel1;
    logic [1:0]  sel0;
    logic [31:0] d1;
    logic [31:0] d0;
    logic        stall;
    logic        kill;
  } obs_t;

  typedef struct {
    string name;
    obs_t  exp;
  } sb_t;

  typedef struct {
    string      name;
    logic       v;
    logic [1:0] en;
    logic [4:0] rs0;
    logic [4:0] rs1;
    logic       we;
    logic [4:0] rd;
    logic       ld;
    logic       redir;
    obs_t       exp;
  } step_t;

  sb_t  sb[$];
  int   checks = 0;
  int   passed = 0;

  function automatic obs_t ob(logic [1:0] s0, logic [31:0] d0, logic [1:0] s1,
                              logic [31:0] d1, logic st, logic k);
    obs_t o;
    o.sel0 = s0; o.d0 = d0; o.sel1 = s1; o.d1 = d1; o.stall = st; o.kill = k;
    return o;
  endfunction

  function automatic step_t mk(string name, logic v, logic [1:0] en,
                               logic [4:0] rs0, logic [4:0] rs1, logic we,
                               logic [4:0] rd, logic ld, logic redir, obs_t exp);
    step_t s;
    s.name = name; s.v = v; s.en = en; s.rs0 = rs0; s.rs1 = rs1;
    s.we = we; s.rd = rd; s.ld = ld; s.redir = redir; s.exp = exp;
    return s;
  endfunction

  // Drive one decode slot and record what the DUT must show for it.
  task automatic apply(input step_t s);
    id_valid   = s.v;
    id_rs_en   = s.en;
    id_rs_addr = {s.rs1, s.rs0};
    id_rd_we   = s.we;
    id_rd_addr = s.rd;
    id_is_load = s.ld;
    redirect   = s.redir;
    sb.push_back('{name: s.name, exp: s.exp});
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_rs_en = 0; id_rs_addr = 0; id_rd_we = 0;
    id_rd_addr = 0; id_is_load = 0; redirect = 0;
  endtask

  // Empty the tag pipeline and let any redirect counter drain.
  task automatic flush();
    idle_inputs();
    repeat (FD) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t got;
    reset_n = 0;
    idle_inputs();
    @(negedge clk);
    checks++; if (stage_we_o !== 3'b000) $display("FAIL reset_we: got %b expected 000", stage_we_o); else passed++;
    checks++; if (stage_rd_o !== 15'd0) $display("FAIL reset_rd: got %h expected 0", stage_rd_o); else passed++;
    got = {fwd_sel_o, fwd_data_o, stall_o, kill_o};
    checks++; if (got !== ob(0, RF0, 0, RF1, 0, 0)) $display("FAIL reset_outputs: got %h expected %h", got, ob(0, RF0, 0, RF1, 0, 0)); else passed++;
    reset_n = 1;
    @(posedge clk); #1;
    $display("test_reset done");
  endtask

  task automatic test_fwd_ex();
    step_t t[$];
    sb_t   e;
    obs_t  got;
    flush();
    stage_data = {32'h3333, 32'h2222, 32'h1234};
    t.push_back(mk("ex_add_x5",  1, 2'b00, 0, 0, 1, 5, 0, 0, ob(0, RF0, 0, RF1, 0, 0)));
    t.push_back(mk("ex_read_x5", 1, 2'b01, 5, 0, 0, 0, 0, 0, ob(1, 32'h1234, 0, RF1, 0, 0)));
    foreach (t[i]) begin
      apply(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      got = {fwd_sel_o, fwd_data_o, stall_o, kill_o};
      checks++; if (got !== e.exp) $display("FAIL %s: got %h expected %h", e.name, got, e.exp); else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_fwd_wb();
    step_t t[$];
    sb_t   e;
    obs_t  got;
    flush();
    stage_data = {32'hBEEF, 32'h2222, 32'h1111};
    t.push_back(mk("wb_add_x5", 1, 2'b00, 0, 0, 1, 5, 0, 0, ob(0, RF0, 0, RF1, 0, 0)));
    t.push_back(mk("wb_add_x6", 1, 2'b00, 0, 0, 1, 6, 0, 0, ob(0, RF0, 0, RF1, 0, 0)));
    t.push_back(mk("wb_add_x7", 1, 2'b00, 0, 0, 1, 7, 0, 0, ob(0, RF0, 0, RF1, 0, 0)));
    t.push_back(mk("wb_read_x6_x5", 1, 2'b11, 6, 5, 0, 0, 0, 0, ob(2, 32'h2222, 3, 32'hBEEF, 0, 0)));
    foreach (t[i]) begin
      apply(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      got = {fwd_sel_o, fwd_data_o, stall_o, kill_o};
      checks++; if (got !== e.exp) $display("FAIL %s: got %h expected %h", e.name, got, e.exp); else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    step_t t[$];
    sb_t   e;
    obs_t  got;
    flush();
    stage_data = {32'h3333_0002, 32'h0000_11D0, 32'h5555_0000};
    t.push_back(mk("lu_lw_x7",     1, 2'b00, 0, 0, 1, 7, 1, 0, ob(0, RF0, 0, RF1, 0, 0)));
    t.push_back(mk("lu_stall",     1, 2'b01, 7, 0, 1, 8, 0, 0, ob(1, 32'h5555_0000, 0, RF1, 1, 0)));
    t.push_back(mk("lu_proceed",   1, 2'b01, 7, 0, 1, 8, 0, 0, ob(2, 32'h0000_11D0, 0, RF1, 0, 0)));
    t.push_back(mk("lu_after",     0, 2'b00, 0, 0, 0, 0, 0, 0, ob(0, RF0, 0, RF1, 0, 0)));
    foreach (t[i]) begin
      apply(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      got = {fwd_sel_o, fwd_data_o, stall_o, kill_o};
      checks++; if (got !== e.exp) $display("FAIL %s: got %h expected %h", e.name, got, e.exp); else passed++;
      if (i == 2) begin
        checks++; if ({stage_we_o, stage_rd_o} !== {3'b010, 5'd0, 5'd7, 5'd0}) $display("FAIL lu_bubble_tags: got we=%b rd=%h expected we=010 rd=%h", stage_we_o, stage_rd_o, {5'd0, 5'd7, 5'd0}); else passed++;
      end
      if (i == 3) begin
        checks++; if ({stage_we_o, stage_rd_o} !== {3'b101, 5'd7, 5'd0, 5'd8}) $display("FAIL lu_accept_tags: got we=%b rd=%h expected we=101 rd=%h", stage_we_o, stage_rd_o, {5'd7, 5'd0, 5'd8}); else passed++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_youngest();
    step_t t[$];
    sb_t   e;
    obs_t  got;
    flush();
    stage_data = {32'hB, 32'h99, 32'hA};
    t.push_back(mk("yg_add_x5a", 1, 2'b00, 0, 0, 1, 5, 0, 0, ob(0, RF0, 0, RF1, 0, 0)));
    t.push_back(mk("yg_add_x6",  1, 2'b00, 0, 0, 1, 6, 0, 0, ob(0, RF0, 0, RF1, 0, 0)));
    t.push_back(mk("yg_add_x5b", 1, 2'b00, 0, 0, 1, 5, 0, 0, ob(0, RF0, 0, RF1, 0, 0)));
    t.push_back(mk("yg_youngest", 1, 2'b11, 5, 0, 1, 0, 0, 0, ob(1, 32'hA, 0, RF1, 0, 0)));
    t.push_back(mk("yg_x0_tag",   1, 2'b11, 5, 0, 0, 0, 0, 0, ob(2, 32'h99, 0, RF1, 0, 0)));
    foreach (t[i]) begin
      apply(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      got = {fwd_sel_o, fwd_data_o, stall_o, kill_o};
      checks++; if (got !== e.exp) $display("FAIL %s: got %h expected %h", e.name, got, e.exp); else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_redirect_stall();
    step_t t[$];
    sb_t   e;
    obs_t  got;
    flush();
    stage_data = {32'hCC02, 32'hCC01, 32'hCC00};
    t.push_back(mk("rd_lw_x9",   1, 2'b00, 0, 0, 1, 9, 1, 0, ob(0, RF0, 0, RF1, 0, 0)));
    t.push_back(mk("rd_kill1",   1, 2'b01, 9, 0, 0, 0, 0, 1, ob(1, 32'hCC00, 0, RF1, 0, 1)));
    t.push_back(mk("rd_kill2",   1, 2'b01, 9, 0, 0, 0, 0, 0, ob(2, 32'hCC01, 0, RF1, 0, 1)));
    t.push_back(mk("rd_resume",  1, 2'b01, 9, 0, 0, 0, 0, 0, ob(3, 32'hCC02, 0, RF1, 0, 0)));
    foreach (t[i]) begin
      apply(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      got = {fwd_sel_o, fwd_data_o, stall_o, kill_o};
      checks++; if (got !== e.exp) $display("FAIL %s: got %h expected %h", e.name, got, e.exp); else passed++;
      if (i == 3) begin
        checks++; if (stage_we_o !== 3'b100) $display("FAIL rd_bubble_tags: got we=%b expected 100", stage_we_o); else passed++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back_redirect();
    step_t t[$];
    sb_t   e;
    obs_t  got;
    flush();
    t.push_back(mk("bb_pulse1", 0, 2'b00, 0, 0, 0, 0, 0, 1, ob(0, RF0, 0, RF1, 0, 1)));
    t.push_back(mk("bb_pulse2", 0, 2'b00, 0, 0, 0, 0, 0, 1, ob(0, RF0, 0, RF1, 0, 1)));
    t.push_back(mk("bb_tail",   0, 2'b00, 0, 0, 0, 0, 0, 0, ob(0, RF0, 0, RF1, 0, 1)));
    t.push_back(mk("bb_done",   0, 2'b00, 0, 0, 0, 0, 0, 0, ob(0, RF0, 0, RF1, 0, 0)));
    foreach (t[i]) begin
      apply(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      got = {fwd_sel_o, fwd_data_o, stall_o, kill_o};
      checks++; if (got !== e.exp) $display("FAIL %s: got %h expected %h", e.name, got, e.exp); else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_squash();
    step_t t[$];
    sb_t   e;
    obs_t  got;
    flush();
    t.push_back(mk("rm_add_x5", 1, 2'b00, 0, 0, 1, 5, 0, 0, ob(0, RF0, 0, RF1, 0, 0)));
    t.push_back(mk("rm_redir",  0, 2'b00, 0, 0, 0, 0, 0, 1, ob(0, RF0, 0, RF1, 0, 1)));
    t.push_back(mk("rm_squash", 0, 2'b00, 0, 0, 0, 0, 0, 0, ob(0, RF0, 0, RF1, 0, 1)));
    foreach (t[i]) begin
      apply(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      got = {fwd_sel_o, fwd_data_o, stall_o, kill_o};
      checks++; if (got !== e.exp) $display("FAIL %s: got %h expected %h", e.name, got, e.exp); else passed++;
      if (i == 2) begin
        checks++; if (stage_we_o !== 3'b010) $display("FAIL rm_pre_tags: got we=%b expected 010", stage_we_o); else passed++;
        reset_n = 0;
        #1;
        checks++; if (stage_we_o !== 3'b000) $display("FAIL rm_we_cleared: got %b expected 000", stage_we_o); else passed++;
        checks++; if (stage_rd_o !== 15'd0) $display("FAIL rm_rd_cleared: got %h expected 0", stage_rd_o); else passed++;
        checks++; if (kill_o !== 1'b0) $display("FAIL rm_kill_cleared: got %b expected 0", kill_o); else passed++;
`ifdef HAZARD_STATS_EN
        checks++; if (stall_count_o !== 32'd0) $display("FAIL rm_stall_count: got %0d expected 0", stall_count_o); else passed++;
        checks++; if (kill_count_o !== 32'd0) $display("FAIL rm_kill_count: got %0d expected 0", kill_count_o); else passed++;
`endif
      end
      @(posedge clk); #1;
    end
    reset_n = 1;
    @(posedge clk); #1;
  endtask

  initial begin
    rf_data    = {RF1, RF0};
    stage_data = '0;
    test_reset();
    test_fwd_ex();
    test_fwd_wb();
    test_load_use();
    test_youngest();
    test_redirect_stall();
    test_back_to_back_redirect();
    test_reset_mid_squash();
    checks++; if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size()); else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
